seg_scan_mux: RTL
=================

# seg_scan_mux

Time-multiplexed driver for the two-digit seven-segment display on the lab board. It sits directly downstream of the counter/BCD stage, which produces the static `seg0`/`seg1` patterns and `indicator`. Each frame it snapshots those inputs once, then scans them onto the shared cathode bus and digit anodes. A blanking gap before each digit suppresses ghosting.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit slot; a frame is 2×`REFRESH_DIV` cycles; legal range ≥ 2.
- `BLANK_CYC`, 16: blank cycles at the start of each slot; legal range 1 ≤ `BLANK_CYC` < `REFRESH_DIV`.

- `clk` in 1: single system clock; all state updates on its rising edge.
- `master_reset` in 1: reset, synchronous, active-high.
- `seg0` in 7: digit-0 (right) segment pattern; active-low; `7'b1000000` is the glyph "0".
- `seg1` in 7: digit-1 (left) segment pattern; same encoding as `seg0`.
- `indicator` in 1: when 1, lights the decimal point on digit 0.
- `an` out 4: digit anodes, active-low; `an[3:2]` are tied to 1.
- `seg_out` out 7: shared cathode bus, active-low.
- `dp` out 1: decimal point, active-low.
- `frame` out 1: one-cycle pulse marking each snapshot.

## Operation
- Internal state:
  - `cnt` counts 0..`REFRESH_DIV`-1 and wraps to 0.
  - `slot` (0/1) toggles on each wrap.
  - Snapshot registers `s0`, `s1` (7 bits) and `si` (1 bit).
- Snapshot: on any edge where the pre-edge values are `slot`=0 and `cnt`=0, capture `s0`←`seg0`, `s1`←`seg1`, `si`←`indicator`.
  - Inputs are not sampled at any other time, so the display cannot tear mid-frame.
- Output decode is registered from the pre-edge `slot`/`cnt`:
  - Blank phase (`cnt` < `BLANK_CYC`): `an`=4'b1111, `seg_out`=7'h7F, `dp`=1.
  - Show, `slot`=0: `an`=4'b1110, `seg_out`=`s0`, `dp`=~`si`.
  - Show, `slot`=1: `an`=4'b1101, `seg_out`=`s1`, `dp`=1.
- `frame` is registered: it is 1 in the cycle after each snapshot edge and 0 otherwise.
- Reset (any edge with `master_reset`=1, including mid-frame):
  - `cnt`=0, `slot`=0, `s0`=`s1`=7'h7F, `si`=0.
  - `an`=4'b1111, `seg_out`=7'h7F, `dp`=1, `frame`=0.
  - The scan restarts; the first edge after release is a snapshot edge.
- At most one anode is ever low. No cycle may show one digit's anode with the other digit's pattern.

## Timing
- Edges are numbered E0, E1, … starting at the first edge with `master_reset`=0.
- Snapshot edges are E0, E(2·`REFRESH_DIV`), E(4·`REFRESH_DIV`), …; `frame` is high in the cycle after each.
- Digit 0 is shown after edges E`BLANK_CYC`..E(`REFRESH_DIV`-1).
- Digit 1 is shown after edges E(`REFRESH_DIV`+`BLANK_CYC`)..E(2·`REFRESH_DIV`-1).
- All remaining cycles are blank.
- Input-to-display latency: an input change becomes visible after the next snapshot edge plus `BLANK_CYC` cycles. This is at most 2·`REFRESH_DIV`+`BLANK_CYC` cycles.
- Input changes between snapshots are ignored, including a value that changes on a snapshot edge and back again before the next one.

## Configuration
- `SEG_LEADING_BLANK_EN` defined: during the slot-1 show phase, if `s1`==7'b1000000, then `an` stays 4'b1111 and `seg_out` stays 7'h7F (leading zero suppressed). Digit 0 is never suppressed.
- `SEG_LEADING_BLANK_EN` undefined: digit 1 is always shown as captured.

## Test plan
All scenarios use `REFRESH_DIV`=8 and `BLANK_CYC`=2.
- Reset check: hold reset 3 cycles, then release → `an`=1111, `seg_out`=7F, `dp`=1, `frame`=0 while in reset; `frame`=1 after E0 only, then again after E16 and E32.
- Scan order: `seg0`=7'h79, `seg1`=7'h24, `indicator`=1.
  - After E0,E1: blank.
  - After E2..E7: `an`=1110, `seg_out`=79, `dp`=0.
  - After E8,E9: blank.
  - After E10..E15: `an`=1101, `seg_out`=24, `dp`=1.
- Snapshot isolation: change `seg0` to 7'h30 after E5 → `seg_out` stays 79 through E15; shows 30 after E18.
- Mid-frame reset: assert reset at E11 for one edge → next cycle fully blank with `frame`=0; after release, the sequence restarts exactly as in scenario 1.
- Leading blank: `seg1`=7'b1000000.
  - With `SEG_LEADING_BLANK_EN`: `an`=1111 after E10..E15.
  - Without it: `an`=1101 and `seg_out`=40 after E10..E15.
- Invariant: over 1000 cycles of random inputs, `an` never has more than one 0 bit, and `an[3:2]`=11 always.

Source files
------------

// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
//
// Time-multiplexed driver for the two-digit seven-segment display. Once per
// frame the static digit patterns and the decimal-point indicator are
// snapshotted. They are then scanned onto the shared cathode bus and the
// digit anodes. Each digit slot opens with a short blanking gap so that the
// previous digit's pattern cannot ghost onto the next anode.
//
// Parameters
//   REFRESH_DIV  clock cycles per digit slot (>= 2); a frame is two slots
//   BLANK_CYC    blank cycles at the start of each slot (1..REFRESH_DIV-1)
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   master_reset  synchronous active-high reset
//   seg0          digit-0 (right) pattern, active-low
//   seg1          digit-1 (left) pattern, active-low
//   indicator     1 lights the decimal point on digit 0
//   an            digit anodes, active-low, an[3:2] always 1
//   seg_out       shared cathode bus, active-low
//   dp            decimal point, active-low
//   frame         one-cycle pulse in the cycle after each snapshot
//
// Optional feature
//   SEG_LEADING_BLANK_EN  when defined, a captured "0" glyph on digit 1 is
//                         suppressed (digit stays dark for the whole slot)
// ---------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic       clk,
    input  logic       master_reset,
    input  logic [6:0] seg0,
    input  logic [6:0] seg1,
    input  logic       indicator,
    output logic [3:0] an,
    output logic [6:0] seg_out,
    output logic       dp,
    output logic       frame
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [6:0]    GLYPH_ALL_OFF = 7'h7F;
    localparam logic [6:0]    GLYPH_ZERO    = 7'b1000000;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          slot_q, slot_d;
    logic [6:0]    s0_q, s0_d;
    logic [6:0]    s1_q, s1_d;
    logic          si_q, si_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_out_q, seg_out_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;

    logic wrap;
    logic snap;
    logic blank;

    always_comb begin
        wrap  = (cnt_q == CNT_MAX);
        // Snapshot only at the very start of the frame; the inputs are
        // ignored everywhere else so a frame can never mix two input sets.
        snap  = (slot_q == 1'b0) && (cnt_q == '0);
        blank = (cnt_q < BLANK_END);

        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        slot_d  = wrap ? ~slot_q : slot_q;
        s0_d    = snap ? seg0 : s0_q;
        s1_d    = snap ? seg1 : s1_q;
        si_d    = snap ? indicator : si_q;
        frame_d = snap;

        an_d      = 4'b1111;
        seg_out_d = GLYPH_ALL_OFF;
        dp_d      = 1'b1;

        // The snapshot edge always falls in a blank phase, so decoding from
        // the registered snapshot never shows a half-updated digit.
        if (!blank) begin
            if (slot_q == 1'b0) begin
                an_d      = 4'b1110;
                seg_out_d = s0_q;
                dp_d      = ~si_q;
            end else begin
`ifdef SEG_LEADING_BLANK_EN
                if (s1_q != GLYPH_ZERO) begin
                    an_d      = 4'b1101;
                    seg_out_d = s1_q;
                end
`else
                an_d      = 4'b1101;
                seg_out_d = s1_q;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (master_reset) begin
            cnt_q     <= '0;
            slot_q    <= 1'b0;
            s0_q      <= GLYPH_ALL_OFF;
            s1_q      <= GLYPH_ALL_OFF;
            si_q      <= 1'b0;
            an_q      <= 4'b1111;
            seg_out_q <= GLYPH_ALL_OFF;
            dp_q      <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            si_q      <= si_d;
            an_q      <= an_d;
            seg_out_q <= seg_out_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
        end
    end

    assign an      = an_q;
    assign seg_out = seg_out_q;
    assign dp      = dp_q;
    assign frame   = frame_q;

`ifdef SEG_LEADING_BLANK_EN
`else
    // Keeps the zero-glyph constant referenced in the default build.
    logic unused_zero;
    assign unused_zero = ^GLYPH_ZERO;
`endif

endmodule
